// File: rtl/execute_unit_if.sv
// rtl/execute_unit_if.sv - ID/EX inputs and EX/MEM outputs of the execute stage
interface execute_unit_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            id_valid;
    logic            ctl_alusrc;
    logic            ctl_memtoreg;
    logic            ctl_regwrite;
    logic            ctl_memread;
    logic            ctl_memwrite;
    logic            ctl_branch;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_in;
    logic [XLEN-1:0] imm_in;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] mem_fwd_data;
    logic [XLEN-1:0] wb_fwd_data;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            busy;
    logic            ex_valid;
    logic            memtoreg_out;
    logic            regwrite_out;
    logic            memread_out;
    logic            memwrite_out;
    logic            branch_taken_out;
    logic [4:0]      rd_out;
    logic [XLEN-1:0] result_out;
    logic [XLEN-1:0] store_data_out;
    logic [XLEN-1:0] pc_imm_out;
    logic [XLEN-1:0] pc_out;

    modport master (
        output flush, id_valid, ctl_alusrc, ctl_memtoreg, ctl_regwrite, ctl_memread,
               ctl_memwrite, ctl_branch, alu_op, funct3, funct7, rd_in, imm_in,
               rs1_data, rs2_data, pc_in, mem_fwd_data, wb_fwd_data, fwd_a, fwd_b,
        input  busy, ex_valid, memtoreg_out, regwrite_out, memread_out, memwrite_out,
               branch_taken_out, rd_out, result_out, store_data_out, pc_imm_out, pc_out
    );

    modport slave (
        input  flush, id_valid, ctl_alusrc, ctl_memtoreg, ctl_regwrite, ctl_memread,
               ctl_memwrite, ctl_branch, alu_op, funct3, funct7, rd_in, imm_in,
               rs1_data, rs2_data, pc_in, mem_fwd_data, wb_fwd_data, fwd_a, fwd_b,
        output busy, ex_valid, memtoreg_out, regwrite_out, memread_out, memwrite_out,
               branch_taken_out, rd_out, result_out, store_data_out, pc_imm_out, pc_out
    );
endinterface

// File: rtl/execute_unit.sv
// rtl/execute_unit.sv - RV32IM execute stage, iterative M unit and EX/MEM register
// Define EXEC_DIV_EN to run DIV/DIVU/REM/REMU on the iterative unit.
module execute_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic          clk,
    input  logic          reset,
    execute_unit_if.slave bus
);
    localparam int SH_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} m_state_t;
    m_state_t state, state_nx;

    logic [XLEN-1:0]   op_a, op_b_raw, op_b, alu_res, sra_res, m_res;
    logic [XLEN-1:0]   hi, lo, b_reg, a_mag, b_mag;
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     mul_sum;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        m_f3;
    logic [SH_W-1:0]   shamt;
    logic neg, neg_nx, a_neg, b_neg, a_sgn, b_sgn;
    logic is_m, m_iter, accept, busy, cond, slt, sltu, base, alt, r_ok, i_ok, use_alt;

    always_comb begin
        case (bus.fwd_a)
            2'b10:   op_a = bus.mem_fwd_data;
            2'b01:   op_a = bus.wb_fwd_data;
            default: op_a = bus.rs1_data;
        endcase
        case (bus.fwd_b)
            2'b10:   op_b_raw = bus.mem_fwd_data;
            2'b01:   op_b_raw = bus.wb_fwd_data;
            default: op_b_raw = bus.rs2_data;
        endcase
    end
    assign op_b    = bus.ctl_alusrc ? bus.imm_in : op_b_raw;
    assign shamt   = op_b[SH_W-1:0];
    assign sra_res = $signed(op_a) >>> shamt;
    assign slt     = $signed(op_a) < $signed(op_b);
    assign sltu    = op_a < op_b;
    assign base    = (bus.funct7 == 7'b0000000);
    assign alt     = (bus.funct7 == 7'b0100000);

    // Encodings outside the base ISA fall through to a zero result.
    always_comb begin
        alu_res = '0;
        r_ok    = base | (alt & (bus.funct3 == 3'b000 | bus.funct3 == 3'b101));
        i_ok    = (bus.funct3 == 3'b001) ? base : (bus.funct3 == 3'b101) ? (base | alt) : 1'b1;
        use_alt = alt & (bus.alu_op == 2'b10 | bus.funct3 == 3'b101);
        case (bus.alu_op)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            default: begin
                if ((bus.alu_op == 2'b10 && r_ok) || (bus.alu_op == 2'b11 && i_ok)) begin
                    case (bus.funct3)
                        3'b000:  alu_res = use_alt ? op_a - op_b : op_a + op_b;
                        3'b001:  alu_res = op_a << shamt;
                        3'b010:  alu_res = {{(XLEN-1){1'b0}}, slt};
                        3'b011:  alu_res = {{(XLEN-1){1'b0}}, sltu};
                        3'b100:  alu_res = op_a ^ op_b;
                        3'b101:  alu_res = use_alt ? sra_res : op_a >> shamt;
                        3'b110:  alu_res = op_a | op_b;
                        default: alu_res = op_a & op_b;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        case (bus.funct3)
            3'b000:  cond = (op_a == op_b);
            3'b001:  cond = (op_a != op_b);
            3'b100:  cond = slt;
            3'b101:  cond = ~slt;
            3'b110:  cond = sltu;
            3'b111:  cond = ~sltu;
            default: cond = 1'b0;
        endcase
    end

    assign is_m = (bus.alu_op == 2'b10) && (bus.funct7 == 7'b0000001);
`ifdef EXEC_DIV_EN
    assign m_iter = is_m;
`else
    assign m_iter = is_m & ~bus.funct3[2];
`endif
    assign accept   = (state == IDLE) & bus.id_valid & m_iter & ~bus.flush;
    assign busy     = accept | (state == RUN);
    assign bus.busy = busy;

    // Signedness by funct3: MUL/MULH/MULHSU/DIV/REM treat A as signed; MUL/MULH/DIV/REM treat B as signed.
    assign a_sgn  = ~(bus.funct3 == 3'b011 || bus.funct3 == 3'b101 || bus.funct3 == 3'b111);
    assign b_sgn  = (bus.funct3 == 3'b000 || bus.funct3 == 3'b001 ||
                     bus.funct3 == 3'b100 || bus.funct3 == 3'b110);
    assign a_neg  = a_sgn & op_a[XLEN-1];
    assign b_neg  = b_sgn & op_b[XLEN-1];
    assign a_mag  = a_neg ? -op_a : op_a;
    assign b_mag  = b_neg ? -op_b : op_b;
    // A zero divisor keeps the quotient unsigned (all ones) and the remainder signed like the dividend.
    assign neg_nx = ~bus.funct3[2] ? (a_neg ^ b_neg) :
                    bus.funct3[1]  ? a_neg : ((a_neg ^ b_neg) & (op_b != '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (cnt == CNT_W'(XLEN - 1)) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (bus.flush) state_nx = IDLE;
    end

    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_reg} : {(XLEN+1){1'b0}});
`ifdef EXEC_DIV_EN
    logic [XLEN:0] div_sh, div_diff;
    assign div_sh   = {hi, lo[XLEN-1]};
    assign div_diff = div_sh - {1'b0, b_reg};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0; hi <= '0; lo <= '0; b_reg <= '0; m_f3 <= '0; neg <= 1'b0;
        end else if (accept) begin
            cnt <= '0; hi <= '0; lo <= a_mag; b_reg <= b_mag; m_f3 <= bus.funct3; neg <= neg_nx;
        end else if (state == RUN) begin
            cnt <= cnt + CNT_W'(1);
`ifdef EXEC_DIV_EN
            if (m_f3[2]) begin
                hi <= div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
                lo <= {lo[XLEN-2:0], ~div_diff[XLEN]};
            end else begin
                hi <= mul_sum[XLEN:1];
                lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
`else
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
`endif
        end
    end

    always_comb begin
        prod  = neg ? -{hi, lo} : {hi, lo};
        m_res = (m_f3 == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef EXEC_DIV_EN
        if (m_f3[2]) begin
            m_res = m_f3[1] ? hi : lo;
            if (neg) m_res = -m_res;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.ex_valid <= 1'b0; bus.memtoreg_out <= 1'b0; bus.regwrite_out <= 1'b0;
            bus.memread_out <= 1'b0; bus.memwrite_out <= 1'b0; bus.branch_taken_out <= 1'b0;
            bus.rd_out <= '0; bus.result_out <= '0; bus.store_data_out <= '0;
            bus.pc_imm_out <= '0; bus.pc_out <= '0;
        end else begin
            bus.rd_out         <= bus.rd_in;
            bus.result_out     <= (state == DONE) ? m_res : alu_res;
            bus.store_data_out <= op_b_raw;
            bus.pc_imm_out     <= bus.pc_in + bus.imm_in;
            bus.pc_out         <= bus.pc_in;
            if (bus.flush || busy) begin
                bus.ex_valid <= 1'b0; bus.memtoreg_out <= 1'b0; bus.regwrite_out <= 1'b0;
                bus.memread_out <= 1'b0; bus.memwrite_out <= 1'b0; bus.branch_taken_out <= 1'b0;
            end else begin
                bus.ex_valid         <= bus.id_valid;
                bus.memtoreg_out     <= bus.id_valid & bus.ctl_memtoreg;
                bus.regwrite_out     <= bus.id_valid & bus.ctl_regwrite;
                bus.memread_out      <= bus.id_valid & bus.ctl_memread;
                bus.memwrite_out     <= bus.id_valid & bus.ctl_memwrite;
                bus.branch_taken_out <= bus.id_valid & bus.ctl_branch & cond;
            end
        end
    end
endmodule

// File: tb/tb_execute_unit.sv
// tb/tb_execute_unit.sv - randomized and directed bench for execute_unit against an arithmetic model
module tb_execute_unit;
    localparam int XLEN = 32;
`ifdef EXEC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    execute_unit_if #(.XLEN(XLEN)) bus ();
    execute_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0]  aop;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1, rs2, imm, pc, memd, wbd;
        logic [1:0]  fa, fb;
        logic        alusrc, branch, memwrite;
        logic [4:0]  rd;
    } op_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint pa, pbs, pbu;
        logic [63:0] p;
        sa = a; sb = b;
        pa = longint'(sa); pbs = longint'(sb); pbu = longint'({32'b0, b});
        if (f3[2] && !DIV_EN) return 32'h0;
        case (f3)
            3'd0: begin p = pa * pbs; return p[31:0]; end
            3'd1: begin p = pa * pbs; return p[63:32]; end
            3'd2: begin p = pa * pbu; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic [4:0] sh;
        logic alt;
        sa = a; sb = b; sh = b[4:0]; alt = (f7 == 7'h20);
        if (aop == 2'b00) return a + b;
        if (aop == 2'b01) return a - b;
        if (aop == 2'b10) begin
            if (f7 == 7'h01) return ref_m(f3, a, b);
            if (f7 != 7'h00 && !(alt && (f3 == 3'd0 || f3 == 3'd5))) return 32'h0;
        end else begin
            if (f3 == 3'd1 && f7 != 7'h00) return 32'h0;
            if (f3 == 3'd5 && f7 != 7'h00 && !alt) return 32'h0;
            if (f3 == 3'd0) alt = 1'b0;
        end
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (alt) return sa >>> sh;
                return a >> sh;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] r, input logic [31:0] m,
                                         input logic [31:0] w);
        if (f == 2'b10) return m;
        if (f == 2'b01) return w;
        return r;
    endfunction

    function automatic op_t mk(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] a, input logic [31:0] b);
        op_t o;
        o.aop = aop; o.f3 = f3; o.f7 = f7; o.rs1 = a; o.rs2 = b;
        o.imm = 32'h0; o.pc = 32'h100; o.memd = 32'h0; o.wbd = 32'h0;
        o.fa = 2'b00; o.fb = 2'b00; o.alusrc = 1'b0; o.branch = 1'b0; o.memwrite = 1'b0; o.rd = 5'd5;
        return o;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [6:0] rand_f7();
        case ($urandom_range(0, 3))
            0: return 7'h20;
            1: return 7'($urandom);
            default: return 7'h00;
        endcase
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o = mk(2'b10, 3'($urandom_range(0, 7)), 7'h00, rand_val(), rand_val());
        o.fa = 2'($urandom_range(0, 3)); o.fb = 2'($urandom_range(0, 3));
        o.memd = rand_val(); o.wbd = rand_val(); o.imm = rand_val();
        o.pc = $urandom; o.rd = 5'($urandom);
        case ($urandom_range(0, 5))
            0: o.f7 = rand_f7();
            1: begin o.aop = 2'b11; o.alusrc = 1'b1; o.f7 = rand_f7(); end
            2: begin o.aop = 2'b01; o.branch = 1'b1; end
            5: begin o.aop = 2'b00; o.alusrc = 1'b1; o.memwrite = 1'($urandom_range(0, 1)); end
            default: o.f7 = 7'h01;
        endcase
        return o;
    endfunction

    task automatic idle_inputs();
        bus.flush = 1'b0; bus.id_valid = 1'b0; bus.ctl_alusrc = 1'b0; bus.ctl_memtoreg = 1'b0;
        bus.ctl_regwrite = 1'b0; bus.ctl_memread = 1'b0; bus.ctl_memwrite = 1'b0; bus.ctl_branch = 1'b0;
        bus.alu_op = 2'b00; bus.funct3 = 3'b000; bus.funct7 = 7'h00; bus.rd_in = 5'd0;
        bus.imm_in = '0; bus.rs1_data = '0; bus.rs2_data = '0; bus.pc_in = '0;
        bus.mem_fwd_data = '0; bus.wb_fwd_data = '0; bus.fwd_a = 2'b00; bus.fwd_b = 2'b00;
    endtask

    task automatic apply(input op_t o);
        bus.alu_op = o.aop; bus.funct3 = o.f3; bus.funct7 = o.f7; bus.rd_in = o.rd;
        bus.rs1_data = o.rs1; bus.rs2_data = o.rs2; bus.imm_in = o.imm; bus.pc_in = o.pc;
        bus.mem_fwd_data = o.memd; bus.wb_fwd_data = o.wbd; bus.fwd_a = o.fa; bus.fwd_b = o.fb;
        bus.ctl_alusrc = o.alusrc; bus.ctl_branch = o.branch; bus.ctl_memwrite = o.memwrite;
        bus.ctl_regwrite = !o.branch && !o.memwrite; bus.ctl_memread = 1'b0; bus.ctl_memtoreg = 1'b0;
        bus.id_valid = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 with EX/MEM back to a bubble.
    task automatic run_op(input string tag, input op_t o, output logic [31:0] res, output logic tk,
                          output logic [31:0] pci, output logic [31:0] st);
        logic [31:0] a, braw, b;
        logic iter;
        int lat, bcnt;
        a    = pick(o.fa, o.rs1, o.memd, o.wbd);
        braw = pick(o.fb, o.rs2, o.memd, o.wbd);
        b    = o.alusrc ? o.imm : braw;
        iter = (o.aop == 2'b10) && (o.f7 == 7'h01) && (DIV_EN || !o.f3[2]);
        apply(o);
        lat = 0; bcnt = 0;
        while (1) begin
            #1;
            if (bus.busy) bcnt++;
            @(posedge clk); #1;
            lat++;
            if (bus.ex_valid || lat >= 200) break;
            bus.mem_fwd_data = $urandom; bus.wb_fwd_data = $urandom;
        end
        check({tag, ".lat"}, lat, iter ? XLEN + 2 : 1);
        check({tag, ".busy"}, bcnt, iter ? XLEN + 1 : 0);
        check({tag, ".res"}, bus.result_out, ref_alu(o.aop, o.f3, o.f7, a, b));
        check({tag, ".tk"}, bus.branch_taken_out, o.branch && ref_cond(o.f3, a, b));
        check({tag, ".pci"}, bus.pc_imm_out, o.pc + o.imm);
        check({tag, ".rd"}, bus.rd_out, o.rd);
        check({tag, ".rw"}, bus.regwrite_out, !o.branch && !o.memwrite);
        check({tag, ".mw"}, bus.memwrite_out, o.memwrite);
        if (!iter) check({tag, ".st"}, bus.store_data_out, braw);
        res = bus.result_out; tk = bus.branch_taken_out; pci = bus.pc_imm_out; st = bus.store_data_out;
        bus.id_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, ".bubble"}, bus.ex_valid, 1'b0);
    endtask

    initial begin
        op_t o;
        logic [31:0] res, pci, st;
        logic tk, seen;
        int guard;
        idle_inputs();
        #12;
        check("rst.ex_valid", bus.ex_valid, 1'b0);
        check("rst.busy", bus.busy, 1'b0);
        check("rst.result", bus.result_out, 32'h0);
        check("rst.regwrite", bus.regwrite_out, 1'b0);
        check("rst.pc_imm", bus.pc_imm_out, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_op("add", mk(2'b10, 3'b000, 7'h00, 32'd5, 32'd7), res, tk, pci, st);
        check("add.const", res, 32'd12);
        run_op("sra", mk(2'b10, 3'b101, 7'h20, 32'h8000_0000, 32'd4), res, tk, pci, st);
        check("sra.const", res, 32'hF800_0000);
        run_op("sltu", mk(2'b10, 3'b011, 7'h00, 32'd1, 32'd2), res, tk, pci, st);
        check("sltu.const", res, 32'd1);
        o = mk(2'b01, 3'b110, 7'h00, 32'hFFFF_FFFF, 32'd1); o.branch = 1'b1; o.imm = 32'h20;
        run_op("bltu", o, res, tk, pci, st);
        check("bltu.tk", tk, 1'b0);
        check("bltu.pci", pci, 32'h120);
        o.f3 = 3'b100;
        run_op("blt", o, res, tk, pci, st);
        check("blt.tk", tk, 1'b1);
        run_op("mulh", mk(2'b10, 3'b001, 7'h01, 32'h8000_0000, 32'h8000_0000), res, tk, pci, st);
        check("mulh.const", res, 32'h4000_0000);
        run_op("div0", mk(2'b10, 3'b100, 7'h01, 32'd7, 32'd0), res, tk, pci, st);
        check("div0.const", res, DIV_EN ? 32'hFFFF_FFFF : 32'h0);
        run_op("remov", mk(2'b10, 3'b110, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF), res, tk, pci, st);
        check("remov.const", res, 32'h0);
        run_op("divu", mk(2'b10, 3'b101, 7'h01, 32'd100, 32'd7), res, tk, pci, st);
        check("divu.const", res, DIV_EN ? 32'd14 : 32'h0);
        o = mk(2'b10, 3'b000, 7'h20, 32'd77, 32'd4); o.fa = 2'b10; o.memd = 32'd9;
        run_op("fwdsub", o, res, tk, pci, st);
        check("fwdsub.const", res, 32'd5);
        o = mk(2'b00, 3'b010, 7'h00, 32'h1000, 32'h1111); o.alusrc = 1'b1; o.imm = 32'd8;
        o.fb = 2'b01; o.wbd = 32'hCAFE_F00D; o.memwrite = 1'b1;
        run_op("store", o, res, tk, pci, st);
        check("store.data", st, 32'hCAFE_F00D);
        check("store.addr", res, 32'h1008);

        for (int i = 0; i < 150; i++) run_op($sformatf("rnd%0d", i), rand_op(), res, tk, pci, st);

        // M op presented together with flush is not accepted.
        apply(mk(2'b10, 3'b000, 7'h01, 32'd3, 32'd5));
        bus.flush = 1'b1;
        #1 check("mflush.busy", bus.busy, 1'b0);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.id_valid = 1'b0;
        #1 check("mflush.idle", bus.busy, 1'b0);
        check("mflush.valid", bus.ex_valid, 1'b0);
        @(posedge clk); #1;

        // Flush at RUN cycle 10.
        apply(mk(2'b10, 3'b001, 7'h01, 32'h8000_0000, 32'h8000_0000));
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1 check("runflush.busy_pre", bus.busy, 1'b1);
        bus.flush = 1'b1; bus.id_valid = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("runflush.busy", bus.busy, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.ex_valid) seen = 1'b1;
        end
        check("runflush.novalid", seen, 1'b0);

        // Flush in the DONE cycle discards the result.
        apply(mk(2'b10, 3'b000, 7'h01, 32'd6, 32'd7));
        @(posedge clk); #1;
        guard = 0;
        while (bus.busy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("doneflush.reached", guard, XLEN);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.id_valid = 1'b0;
        check("doneflush.valid", bus.ex_valid, 1'b0);
        @(posedge clk); #1;
        check("doneflush.after", bus.ex_valid, 1'b0);

        // Reset asserted mid-RUN abandons the op.
        apply(mk(2'b10, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        repeat (6) @(posedge clk);
        #3;
        reset = 1'b0; bus.id_valid = 1'b0;
        #1;
        check("midrst.busy", bus.busy, 1'b0);
        check("midrst.valid", bus.ex_valid, 1'b0);
        check("midrst.result", bus.result_out, 32'h0);
        check("midrst.store", bus.store_data_out, 32'h0);
        check("midrst.pc", bus.pc_out, 32'h0);
        check("midrst.pc_imm", bus.pc_imm_out, 32'h0);
        check("midrst.rd", bus.rd_out, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_op("postrst", mk(2'b10, 3'b000, 7'h00, 32'd20, 32'd22), res, tk, pci, st);
        check("postrst.const", res, 32'd42);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
